decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_pkg.sv | 35 +++
 rtl/decode_queue_core.sv | 127 ++++++++++++
 rtl/decode_queue.sv | 126 ++++++++++++
 tb/tb_decode_queue.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared definitions for the decode queue: widths, opcode constants,
// the raw queue entry layout and the immediate-format selector.
package decode_queue_pkg;

   localparam int INST_WID = 32;
   localparam int ADDR_WID = 32;
   localparam int REG_WID  = 5;

   localparam logic [6:0] OPCODE_L     = 7'b0000011;
   localparam logic [6:0] OPCODE_S     = 7'b0100011;
   localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
   localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
   localparam logic [6:0] OPCODE_B     = 7'b1100011;
   localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
   localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
   localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

   typedef struct packed {
      logic [INST_WID-1:0] inst;
      logic [ADDR_WID-1:0] pc;
      logic                pred_jump;
   } entry_t;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_ISH,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

endpackage

// File: rtl/decode_queue_core.sv
// Purely combinational instruction decoder: splits one raw instruction into
// fields, sign-extended immediate, operand-usage flags and an illegal flag.
module decode_core
   import decode_queue_pkg::*;
(
   input  logic [INST_WID-1:0] i_inst,
   output logic [6:0]          o_opcode,
   output logic [2:0]          o_funct3,
   output logic                o_funct7,
   output logic [REG_WID-1:0]  o_rd,
   output logic [REG_WID-1:0]  o_rs1,
   output logic [REG_WID-1:0]  o_rs2,
   output logic [INST_WID-1:0] o_imm,
   output logic                o_use_rd,
   output logic                o_use_rs1,
   output logic                o_use_rs2,
   output logic                o_illegal
);

   logic [6:0]         w_op;
   logic [2:0]         w_f3;
   logic [REG_WID-1:0] w_rd;
   logic [REG_WID-1:0] w_rs1;
   logic [REG_WID-1:0] w_rs2;
   imm_fmt_e           w_fmt;
   logic               w_has_rd;
   logic               w_has_rs1;
   logic               w_has_rs2;
   logic               w_has_f3;
   logic               w_has_f7;
   logic               w_illegal;
   logic               w_is_shift;

   assign w_op       = i_inst[6:0];
   assign w_rd       = i_inst[11:7];
   assign w_f3       = i_inst[14:12];
   assign w_rs1      = i_inst[19:15];
   assign w_rs2      = i_inst[24:20];
   assign w_is_shift = (w_f3 == 3'b001) | (w_f3 == 3'b101);

   always_comb begin
      w_fmt     = FMT_NONE;
      w_has_rd  = 1'b0;
      w_has_rs1 = 1'b0;
      w_has_rs2 = 1'b0;
      w_has_f3  = 1'b0;
      w_has_f7  = 1'b0;
      w_illegal = 1'b0;
      case (w_op)
         OPCODE_L: begin
            w_fmt     = FMT_I;
            w_has_rd  = 1'b1;
            w_has_rs1 = 1'b1;
            w_has_f3  = 1'b1;
         end
         OPCODE_S: begin
            w_fmt     = FMT_S;
            w_has_rs1 = 1'b1;
            w_has_rs2 = 1'b1;
            w_has_f3  = 1'b1;
         end
         OPCODE_CAL: begin
            w_has_rd  = 1'b1;
            w_has_rs1 = 1'b1;
            w_has_rs2 = 1'b1;
            w_has_f3  = 1'b1;
            w_has_f7  = 1'b1;
         end
         OPCODE_CALI: begin
            w_fmt     = w_is_shift ? FMT_ISH : FMT_I;
            w_has_rd  = 1'b1;
            w_has_rs1 = 1'b1;
            w_has_f3  = 1'b1;
            w_has_f7  = w_is_shift;
         end
         OPCODE_B: begin
            w_fmt     = FMT_B;
            w_has_rs1 = 1'b1;
            w_has_rs2 = 1'b1;
            w_has_f3  = 1'b1;
         end
         OPCODE_LUI, OPCODE_AUIPC: begin
            w_fmt     = FMT_U;
            w_has_rd  = 1'b1;
         end
         OPCODE_JAL: begin
            w_fmt     = FMT_J;
            w_has_rd  = 1'b1;
         end
         OPCODE_JALR: begin
            w_fmt     = FMT_I;
            w_has_rd  = 1'b1;
            w_has_rs1 = 1'b1;
            w_has_f3  = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      o_imm = '0;
      case (w_fmt)
         FMT_I:   o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
         FMT_ISH: o_imm = {27'd0, i_inst[24:20]};
         FMT_S:   o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         FMT_B:   o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
         FMT_U:   o_imm = {i_inst[31:12], 12'd0};
         FMT_J:   o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

   // Register fields a format does not carry read as zero; rd = x0 is never a write.
   assign o_opcode  = w_op;
   assign o_funct3  = w_has_f3  ? w_f3  : '0;
   assign o_funct7  = w_has_f7  & i_inst[30];
   assign o_rd      = w_has_rd  ? w_rd  : '0;
   assign o_rs1     = w_has_rs1 ? w_rs1 : '0;
   assign o_rs2     = w_has_rs2 ? w_rs2 : '0;
   assign o_use_rd  = w_has_rd & (w_rd != '0);
   assign o_use_rs1 = w_has_rs1;
   assign o_use_rs2 = w_has_rs2;
   assign o_illegal = w_illegal;

endmodule

// File: rtl/decode_queue.sv
// Instruction queue holding raw fetched instructions; the head entry is
// decoded combinationally and presented to dispatch.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rollback,
   input  logic                in_valid,
   input  logic [INST_WID-1:0] in_inst,
   input  logic [ADDR_WID-1:0] in_pc,
   input  logic                in_pred_jump,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [6:0]          out_opcode,
   output logic [2:0]          out_funct3,
   output logic                out_funct7,
   output logic [REG_WID-1:0]  out_rd,
   output logic [REG_WID-1:0]  out_rs1,
   output logic [REG_WID-1:0]  out_rs2,
   output logic [INST_WID-1:0] out_imm,
   output logic [ADDR_WID-1:0] out_pc,
   output logic                out_pred_jump,
   output logic                out_use_rd,
   output logic                out_use_rs1,
   output logic                out_use_rs2,
   output logic                out_illegal,
   output logic [CNT_W-1:0]    count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   entry_t             r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_push;
   logic               w_pop;
   entry_t             w_head;
   logic [6:0]         w_opcode;
   logic [2:0]         w_funct3;
   logic               w_funct7;
   logic [REG_WID-1:0] w_rd;
   logic [REG_WID-1:0] w_rs1;
   logic [REG_WID-1:0] w_rs2;
   logic [INST_WID-1:0] w_imm;
   logic               w_use_rd;
   logic               w_use_rs1;
   logic               w_use_rs2;
   logic               w_illegal;

   // in_ready looks only at occupancy, so a full queue refuses a push even
   // when the head is popped in the same cycle.
   assign in_ready  = (r_count != FULL_CNT) & rst;
   assign out_valid = (r_count != '0) & ~rollback;
   assign w_push    = in_valid & in_ready & rdy & ~rollback;
   assign w_pop     = out_valid & out_ready & rdy;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= '{inst: in_inst, pc: in_pc, pred_jump: in_pred_jump};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (rdy) begin
         if (rollback) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign w_head = r_mem[r_rptr];

   decode_core u_decode_core (
      .i_inst    (w_head.inst),
      .o_opcode  (w_opcode),
      .o_funct3  (w_funct3),
      .o_funct7  (w_funct7),
      .o_rd      (w_rd),
      .o_rs1     (w_rs1),
      .o_rs2     (w_rs2),
      .o_imm     (w_imm),
      .o_use_rd  (w_use_rd),
      .o_use_rs1 (w_use_rs1),
      .o_use_rs2 (w_use_rs2),
      .o_illegal (w_illegal)
   );

   // Storage is never reset, so every data output is gated by out_valid.
   assign out_opcode    = out_valid ? w_opcode         : '0;
   assign out_funct3    = out_valid ? w_funct3         : '0;
   assign out_funct7    = out_valid & w_funct7;
   assign out_rd        = out_valid ? w_rd             : '0;
   assign out_rs1       = out_valid ? w_rs1            : '0;
   assign out_rs2       = out_valid ? w_rs2            : '0;
   assign out_imm       = out_valid ? w_imm            : '0;
   assign out_pc        = out_valid ? w_head.pc        : '0;
   assign out_pred_jump = out_valid & w_head.pred_jump;
   assign out_use_rd    = out_valid & w_use_rd;
   assign out_use_rs1   = out_valid & w_use_rs1;
   assign out_use_rs2   = out_valid & w_use_rs2;
   assign out_illegal   = out_valid & w_illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: queue-level reference model with
// per-cycle comparison plus hand-computed literal checks.
module tb_decode_queue;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst, rdy, rollback, in_valid, in_pred_jump, out_ready;
   logic [31:0]      in_inst, in_pc;
   logic             in_ready, out_valid, out_funct7, out_pred_jump;
   logic [6:0]       out_opcode;
   logic [2:0]       out_funct3;
   logic [4:0]       out_rd, out_rs1, out_rs2;
   logic [31:0]      out_imm, out_pc;
   logic             out_use_rd, out_use_rs1, out_use_rs2, out_illegal;
   logic [CNT_W-1:0] count;

   always #5 clk = ~clk;

   decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
      .in_pred_jump(in_pred_jump), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_pc(out_pc), .out_pred_jump(out_pred_jump),
      .out_use_rd(out_use_rd), .out_use_rs1(out_use_rs1),
      .out_use_rs2(out_use_rs2), .out_illegal(out_illegal), .count(count)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pj;
   } ent_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm, pc;
      logic        pj, urd, urs1, urs2, ill;
   } exp_t;

   ent_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the instruction-set rules: pick the format, then
   // which fields it carries.
   function automatic exp_t golden(input logic [31:0] w, input logic [31:0] pc, input logic pj);
      exp_t x;
      byte  fmt;
      bit   hrd, hrs1, hrs2, hf3, shift;
      x = '0;
      x.opcode = w[6:0];
      x.pc = pc;
      x.pj = pj;
      hrd = 0; hrs1 = 0; hrs2 = 0; hf3 = 0;
      shift = (w[14:12] == 3'd1) || (w[14:12] == 3'd5);
      case (w[6:0])
         7'h03: begin fmt = "I"; hrd = 1; hrs1 = 1; hf3 = 1; end
         7'h23: begin fmt = "S"; hrs1 = 1; hrs2 = 1; hf3 = 1; end
         7'h33: begin fmt = "R"; hrd = 1; hrs1 = 1; hrs2 = 1; hf3 = 1; end
         7'h13: begin fmt = shift ? "H" : "I"; hrd = 1; hrs1 = 1; hf3 = 1; end
         7'h63: begin fmt = "B"; hrs1 = 1; hrs2 = 1; hf3 = 1; end
         7'h37, 7'h17: begin fmt = "U"; hrd = 1; end
         7'h6F: begin fmt = "J"; hrd = 1; end
         7'h67: begin fmt = "I"; hrd = 1; hrs1 = 1; hf3 = 1; end
         default: fmt = "?";
      endcase
      case (fmt)
         "I": x.imm = 32'($signed(w[31:20]));
         "H": x.imm = 32'(w[24:20]);
         "S": x.imm = 32'($signed({w[31:25], w[11:7]}));
         "B": x.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         "U": x.imm = w & 32'hFFFFF000;
         "J": x.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         default: x.imm = 32'd0;
      endcase
      x.funct7 = (fmt == "R" || fmt == "H") ? w[30] : 1'b0;
      x.funct3 = hf3 ? w[14:12] : 3'd0;
      x.rd   = hrd  ? w[11:7]  : 5'd0;
      x.rs1  = hrs1 ? w[19:15] : 5'd0;
      x.rs2  = hrs2 ? w[24:20] : 5'd0;
      x.urd  = hrd && (w[11:7] != 5'd0);
      x.urs1 = hrs1;
      x.urs2 = hrs2;
      x.ill  = (fmt == "?");
      return x;
   endfunction

   // Queue model: occupancy decides readiness, rollback flushes, rdy freezes.
   always @(posedge clk or negedge rst) begin : model
      bit push, pop;
      if (!rst) begin
         q.delete();
      end else if (rdy) begin
         push = in_valid && (q.size() != DEPTH) && !rollback;
         pop  = (q.size() != 0) && !rollback && out_ready;
         if (rollback) begin
            q.delete();
         end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{inst: in_inst, pc: in_pc, pj: in_pred_jump});
         end
      end
   end

   always @(negedge clk) begin : compare
      int   c;
      bit   v;
      exp_t e;
      if (chk_en) begin
         c = rst ? q.size() : 0;
         v = (c != 0) && !rollback;
         e = v ? golden(q[0].inst, q[0].pc, q[0].pj) : '0;
         chk("count",     32'(count),       32'(c));
         chk("in_ready",  32'(in_ready),    32'((c != DEPTH) && rst));
         chk("out_valid", 32'(out_valid),   32'(v));
         chk("opcode",    32'(out_opcode),  32'(e.opcode));
         chk("funct3",    32'(out_funct3),  32'(e.funct3));
         chk("funct7",    32'(out_funct7),  32'(e.funct7));
         chk("rd",        32'(out_rd),      32'(e.rd));
         chk("rs1",       32'(out_rs1),     32'(e.rs1));
         chk("rs2",       32'(out_rs2),     32'(e.rs2));
         chk("imm",       out_imm,          e.imm);
         chk("pc",        out_pc,           e.pc);
         chk("pred_jump", 32'(out_pred_jump), 32'(e.pj));
         chk("use_rd",    32'(out_use_rd),  32'(e.urd));
         chk("use_rs1",   32'(out_use_rs1), 32'(e.urs1));
         chk("use_rs2",   32'(out_use_rs2), 32'(e.urs2));
         chk("illegal",   32'(out_illegal), 32'(e.ill));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc, input logic pj);
      in_valid     = 1'b1;
      in_inst      = inst;
      in_pc        = pc;
      in_pred_jump = pj;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [31:0] vec [0:11];

   initial begin
      vec = '{32'hFFC0A103, 32'h0020A423, 32'h002081B3, 32'h402081B3,
              32'h010000EF, 32'h00008067, 32'h00001297, 32'h00000013,
              32'h01F09093, 32'h4020D113, 32'h00B50463, 32'h80000537};
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
      in_inst = '0; in_pc = '0; in_pred_jump = 1'b0; out_ready = 1'b0;

      #3 rst = 1'b0;
      #1;
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk_en = 1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      tick();

      // addi x1,x0,5
      drive_push(32'h00500093, 32'h0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("addi_valid",  32'(out_valid),  32'd1);
      chk("addi_opcode", 32'(out_opcode), 32'h13);
      chk("addi_rd",     32'(out_rd),     32'd1);
      chk("addi_rs1",    32'(out_rs1),    32'd0);
      chk("addi_imm",    out_imm,         32'd5);
      chk("addi_use_rd", 32'(out_use_rd), 32'd1);
      chk("addi_use_rs2", 32'(out_use_rs2), 32'd0);
      chk("addi_funct7", 32'(out_funct7), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // beq x1,x2,-4
      drive_push(32'hFE208EE3, 32'h10, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("beq_imm",     out_imm,          32'hFFFFFFFC);
      chk("beq_use_rs1", 32'(out_use_rs1), 32'd1);
      chk("beq_use_rs2", 32'(out_use_rs2), 32'd1);
      chk("beq_use_rd",  32'(out_use_rd),  32'd0);
      chk("beq_rs2",     32'(out_rs2),     32'd2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // srai x5,x6,3 then lui x3,0x12345
      drive_push(32'h40335293, 32'h20, 1'b0);
      tick();
      drive_push(32'h123451B7, 32'h24, 1'b0);
      chk("srai_imm",    out_imm,         32'd3);
      chk("srai_funct7", 32'(out_funct7), 32'd1);
      chk("srai_rs1",    32'(out_rs1),    32'd6);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("lui_imm",     out_imm,          32'h12345000);
      chk("lui_rd",      32'(out_rd),      32'd3);
      chk("lui_use_rs1", 32'(out_use_rs1), 32'd0);
      tick();
      out_ready = 1'b0;

      // Five pushes into a four-deep queue with dispatch stalled
      for (int i = 0; i < 5; i++) begin
         drive_push(32'h00000093 | (32'(i + 1) << 20), 32'(32'h100 + 4 * i), 1'b0);
         tick();
         chk("fill_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
      chk("fill_count", 32'(count), 32'd4);

      // Pop and push together while full: push refused
      drive_push(32'hDEAD0013, 32'h200, 1'b0);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("fullpop_count",    32'(count),    32'd3);
      chk("fullpop_in_ready", 32'(in_ready), 32'd1);

      // Rollback with a concurrent push
      rollback = 1'b1;
      drive_push(32'h00700093, 32'h300, 1'b1);
      #1;
      chk("rb_valid_now", 32'(out_valid), 32'd0);
      tick();
      rollback = 1'b0;
      in_valid = 1'b0;
      chk("rb_count", 32'(count),     32'd0);
      chk("rb_valid", 32'(out_valid), 32'd0);
      tick();
      chk("rb_not_stored", 32'(count), 32'd0);

      // Frozen while rdy is low, rollback included
      drive_push(32'h00100113, 32'h400, 1'b0);
      tick();
      drive_push(32'h00200193, 32'h404, 1'b1);
      tick();
      rdy = 1'b0;
      rollback = 1'b1;
      out_ready = 1'b1;
      drive_push(32'h00300213, 32'h408, 1'b0);
      tick();
      tick();
      chk("frozen_count", 32'(count), 32'd2);
      rdy = 1'b1;
      rollback = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;

      // Mixed instruction stream with intermittent dispatch stalls
      for (int i = 0; i < 12; i++) begin
         drive_push(vec[i], 32'(32'h1000 + 4 * i), 1'(i % 2));
         out_ready = (i % 3) != 0;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      out_ready = 1'b0;

      // Unknown opcode, then reset in the middle of traffic
      drive_push(32'h0000007F, 32'h2000, 1'b0);
      tick();
      chk("ill_flag",    32'(out_illegal), 32'd1);
      chk("ill_use_rd",  32'(out_use_rd),  32'd0);
      chk("ill_use_rs1", 32'(out_use_rs1), 32'd0);
      chk("ill_use_rs2", 32'(out_use_rs2), 32'd0);
      chk("ill_imm",     out_imm,          32'd0);
      drive_push(32'h00500093, 32'h2004, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_count",    32'(count),    32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_count",    32'(count),    32'd0);
      tick();
      tick();

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
